// File: rtl/sram_ctrl_pkg.sv
// Shared geometry defaults and types for the 1rw1r SRAM front-end.
package sram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH      = 24;
  localparam int DEF_ADDR_WIDTH      = 5;
  localparam int DEF_NUM_WMASKS      = DEF_DATA_WIDTH / 8;
  localparam int DEF_MAX_OUTSTANDING = 3;
  localparam int RD_STAGES           = 2;   // issue, capture
  localparam int COLL_CNT_W          = 16;

  typedef struct packed {
    logic                      we;
    logic [DEF_NUM_WMASKS-1:0] wmask;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } a_req_t;

  function automatic logic [COLL_CNT_W-1:0] sat_inc(input logic [COLL_CNT_W-1:0] v);
    return (&v) ? v : v + COLL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// In-order response buffer; head stays stable until popped.
module sram_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && valid_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

endmodule

// File: rtl/sram_1rw1r_ctrl.sv
// Two valid/ready request ports in front of an OpenRAM 1rw1r macro, with
// credit-limited reads, per-port response FIFOs and write/read collision blocking.
module sram_1rw1r_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int NUM_WMASKS      = DEF_NUM_WMASKS,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [NUM_WMASKS-1:0] a_req_wmask,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  input  logic                  a_rsp_ready,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  output logic                  b_rsp_valid,
  input  logic                  b_rsp_ready,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic                  sram_clk0,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_clk1,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,
  output logic [15:0]           collision_cnt
);

  localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  a_req_t                  a_req, a_reg_q;
  logic                    csb0_q, csb1_q;
  logic [ADDR_WIDTH-1:0]   addr1_q;
  logic [CNT_W-1:0]        a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [RD_STAGES-1:0]    a_vld_pipe_q, b_vld_pipe_q;
  logic [COLL_CNT_W-1:0]   coll_q, coll_d;
  logic                    a_acc, a_rd_acc, b_acc, a_pop, b_pop, collide;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] n;
    n = c;
    if (inc && !dec)      n = c + CNT_W'(1);
    else if (!inc && dec) n = c - CNT_W'(1);
    return n;
  endfunction

  assign a_req = '{we: a_req_we, wmask: a_req_wmask, addr: a_req_addr, wdata: a_req_wdata};

  // A response leaving this cycle frees its credit now, so a port can stream
  // one read per cycle with only MAX_OUTSTANDING credits.
  assign a_pop       = a_rsp_valid && a_rsp_ready;
  assign b_pop       = b_rsp_valid && b_rsp_ready;
  assign a_req_ready = (a_cnt_q < CNT_MAX) || a_pop;
  assign a_acc       = a_req_valid && a_req_ready;
  assign a_rd_acc    = a_acc && !a_req_we;

  assign collide     = a_acc && a_req_we && (a_req_addr == b_req_addr);
  assign b_req_ready = ((b_cnt_q < CNT_MAX) || b_pop) && !collide;
  assign b_acc       = b_req_valid && b_req_ready;

  always_comb begin
    a_cnt_d = cnt_next(a_cnt_q, a_rd_acc, a_pop);
    b_cnt_d = cnt_next(b_cnt_q, b_acc, b_pop);
    coll_d  = (b_req_valid && collide) ? sat_inc(coll_q) : coll_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg_q      <= '0;
      csb0_q       <= 1'b1;
      csb1_q       <= 1'b1;
      addr1_q      <= '0;
      a_cnt_q      <= '0;
      b_cnt_q      <= '0;
      a_vld_pipe_q <= '0;
      b_vld_pipe_q <= '0;
      coll_q       <= '0;
    end else begin
      csb0_q       <= !a_acc;
      csb1_q       <= !b_acc;
      if (a_acc) a_reg_q <= a_req;
      if (b_acc) addr1_q <= b_req_addr;
      a_cnt_q      <= a_cnt_d;
      b_cnt_q      <= b_cnt_d;
      a_vld_pipe_q <= {a_vld_pipe_q[RD_STAGES-2:0], a_rd_acc};
      b_vld_pipe_q <= {b_vld_pipe_q[RD_STAGES-2:0], b_acc};
      coll_q       <= coll_d;
    end
  end

  assign sram_clk0     = clk;
  assign sram_clk1     = clk;
  assign sram_csb0     = csb0_q;
  assign sram_web0     = !a_reg_q.we;
  assign sram_wmask0   = a_reg_q.wmask;
  assign sram_addr0    = a_reg_q.addr;
  assign sram_din0     = a_reg_q.wdata;
  assign sram_csb1     = csb1_q;
  assign sram_addr1    = addr1_q;
  assign collision_cnt = coll_q;

  // dout is only looked at when the capture stage is valid.
  sram_rsp_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(DATA_WIDTH)) u_a_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (a_vld_pipe_q[RD_STAGES-1]),
    .push_data_i (sram_dout0),
    .pop_i       (a_rsp_ready),
    .valid_o     (a_rsp_valid),
    .data_o      (a_rsp_rdata)
  );

  sram_rsp_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(DATA_WIDTH)) u_b_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (b_vld_pipe_q[RD_STAGES-1]),
    .push_data_i (sram_dout1),
    .pop_i       (b_rsp_ready),
    .valid_o     (b_rsp_valid),
    .data_o      (b_rsp_rdata)
  );

endmodule
